// File: rtl/ram_uart_dumper.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ram_uart_dumper: streams a 1-bit-wide RAM out over uart_tx, 8 bits per byte,
// LSB first. Revision: 1.0
// ----------------------------------------------------------------------------
module ram_uart_dumper #(
  parameter int DEPTH  = 784,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic              ram_q,
  input  logic              tx_rdy,
  output logic              tx_start,
  output logic [7:0]        tx_data
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_SEND = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] bidx, bidx_nxt;
  logic [7:0]        shift, shift_nxt;
  logic [7:0]        tx_data_nxt;
  logic              guard, guard_nxt;
  logic              busy_nxt, done_nxt, tx_start_nxt;
  logic              last_bit;

  assign last_bit = (bidx == LAST_IDX);
  assign ram_addr = bidx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      bidx     <= '0;
      shift    <= 8'h00;
      tx_data  <= 8'h00;
      tx_start <= 1'b0;
      guard    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      bidx     <= bidx_nxt;
      shift    <= shift_nxt;
      tx_data  <= tx_data_nxt;
      tx_start <= tx_start_nxt;
      guard    <= guard_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    bidx_nxt     = bidx;
    shift_nxt    = shift;
    tx_data_nxt  = tx_data;
    tx_start_nxt = 1'b0;
    guard_nxt    = 1'b0;
    busy_nxt     = busy;
    done_nxt     = 1'b0;

    unique case (state)
      S_IDLE: begin
        // done is still high in the first IDLE cycle; a start there is dropped
        if (start && !done) begin
          bidx_nxt  = '0;
          shift_nxt = 8'h00;
          busy_nxt  = 1'b1;
          state_nxt = S_RD;
        end
      end
      S_RD: begin
        state_nxt = S_CAP;
      end
      S_CAP: begin
        shift_nxt[bidx[2:0]] = ram_q;
        if (bidx[2:0] == 3'd7 || last_bit) begin
          state_nxt = S_SEND;
        end else begin
          bidx_nxt  = bidx + 1'b1;
          state_nxt = S_RD;
        end
      end
      S_SEND: begin
        // guard masks the stale tx_rdy seen in the cycle after a launch
        if (tx_rdy && !guard) begin
          tx_start_nxt = 1'b1;
          tx_data_nxt  = shift;
          shift_nxt    = 8'h00;
          guard_nxt    = 1'b1;
          if (last_bit) begin
            state_nxt = S_FIN;
          end else begin
            bidx_nxt  = bidx + 1'b1;
            state_nxt = S_RD;
          end
        end
      end
      S_FIN: begin
        if (tx_rdy && !guard) begin
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_uart_dumper.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ram_uart_dumper: randomized self-checking bench against a byte-level
// model of the RAM dump. Revision: 1.0
// ----------------------------------------------------------------------------
module tb_ram_uart_dumper;

  localparam int DEPTH = 784;
  localparam int EXP_N = (DEPTH + 7) / 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, tx_start, tx_rdy;
  logic [9:0] ram_addr;
  logic       ram_q = 1'b0;
  logic [7:0] tx_data;

  logic       start12 = 1'b0;
  logic       busy12, done12, tx_start12;
  logic       tx_rdy12 = 1'b1;
  logic [3:0] addr12;
  logic       q12 = 1'b0;
  logic [7:0] tx_data12;

  bit         mem [0:1023];
  logic [7:0] exp_b [0:127];
  logic [7:0] exp12 [0:1];

  int  n_chk = 0, n_err = 0;
  int  tx_total = 0, base = 0, done_total = 0;
  int  n12 = 0, done12_cnt = 0;
  int  rdy_len = 100, cnt = 0;
  bit  rdy_hold = 1'b0, rand_len = 1'b0, chk_order = 1'b0;
  logic       prev_start = 1'b0, prev_busy = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [9:0] prev_addr = '0;

  always #10 clk = ~clk;

  ram_uart_dumper #(.DEPTH(DEPTH), .ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .ram_addr(ram_addr), .ram_q(ram_q), .tx_rdy(tx_rdy),
    .tx_start(tx_start), .tx_data(tx_data)
  );

  ram_uart_dumper #(.DEPTH(12), .ADDR_W(4)) dut12 (
    .clk(clk), .rst_n(rst_n), .start(start12), .busy(busy12), .done(done12),
    .ram_addr(addr12), .ram_q(q12), .tx_rdy(tx_rdy12),
    .tx_start(tx_start12), .tx_data(tx_data12)
  );

  // Synchronous-read RAMs; the small one holds ones only at valid addresses
  always @(posedge clk) begin
    ram_q <= mem[ram_addr];
    q12   <= (addr12 < 4'd12);
  end

  // UART model: busy for rdy_len cycles after each launch
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cnt <= 0;
    else if (tx_start) cnt <= rdy_len;
    else if (cnt != 0) cnt <= cnt - 1;
  end
  assign tx_rdy = (cnt == 0) && !rdy_hold;

  function automatic void check(input bit ok, input string name, input int act, input int req);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, req, req, $time);
    end
  endfunction

  function automatic void build_exp();
    for (int k = 0; k < EXP_N; k++) begin
      int b;
      b = 0;
      for (int i = 0; i < 8; i++)
        if (8 * k + i < DEPTH && mem[8 * k + i]) b += (1 << i);
      exp_b[k] = 8'(b);
    end
  endfunction

  function automatic void fill_random();
    for (int n = 0; n < 1024; n++) mem[n] = bit'($urandom_range(0, 1));
  endfunction

  task automatic check_cycle();
    if (rst_n) begin
      if (tx_start) begin
        int idx, want;
        idx  = tx_total - base;
        want = (idx >= 0 && idx < EXP_N) ? int'(exp_b[idx]) : -1;
        check(int'(tx_data) == want, "tx_byte", int'(tx_data), want);
        check(!prev_start, "tx_start_back_to_back", 1, 0);
        tx_total++;
        if (rand_len) rdy_len = $urandom_range(0, 20);
      end else begin
        check(tx_data === prev_data, "tx_data_hold", int'(tx_data), int'(prev_data));
      end
      if (busy) check(int'(ram_addr) < DEPTH, "ram_addr_range", int'(ram_addr), DEPTH - 1);
      if (chk_order && busy && prev_busy)
        check(ram_addr == prev_addr || int'(ram_addr) == int'(prev_addr) + 1,
              "ram_addr_order", int'(ram_addr), int'(prev_addr));
      if (done) begin
        done_total++;
        check(tx_total - base == EXP_N, "bytes_at_done", tx_total - base, EXP_N);
        check(!busy, "busy_at_done", int'(busy), 0);
      end
      if (tx_start12) begin
        int want12;
        want12 = (n12 < 2) ? int'(exp12[n12]) : -1;
        check(int'(tx_data12) == want12, "tx_byte_d12", int'(tx_data12), want12);
        n12++;
      end
      if (done12) begin
        done12_cnt++;
        check(n12 == 2, "bytes_at_done_d12", n12, 2);
      end
    end
    prev_start = tx_start;
    prev_data  = tx_data;
    prev_addr  = ram_addr;
    prev_busy  = busy;
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
  endtask

  // Runs a dump; stop_at>=0 returns early once that many bytes have gone out
  task automatic run_dump(input bit poke, input int stop_at, input int hold_cyc);
    int  d0, cyc;
    bit  poked;
    build_exp();
    base     = tx_total;
    d0       = done_total;
    poked    = 1'b0;
    rdy_hold = (hold_cyc > 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check(busy === 1'b1, "busy_after_start", int'(busy), 1);
    cyc = 0;
    while (done_total == d0 && cyc < 30000) begin
      if (stop_at >= 0 && tx_total - base >= stop_at) return;
      if (hold_cyc > 0 && cyc == hold_cyc) begin
        check(tx_total == base, "no_launch_while_held", tx_total - base, 0);
        rdy_hold = 1'b0;
        tick();
        cyc++;
        check(tx_total - base == 1, "launch_after_release", tx_total - base, 1);
      end
      if (poke && !poked && tx_total - base == 10) begin
        start = 1'b1;
        poked = 1'b1;
      end
      tick();
      start = 1'b0;
      cyc++;
    end
    check(done_total == d0 + 1, "done_seen", done_total - d0, 1);
    if (poke) start = 1'b1;
    tick();
    start = 1'b0;
    repeat (40) tick();
    check(tx_total - base == EXP_N, "byte_count", tx_total - base, EXP_N);
    check(done_total == d0 + 1, "single_done", done_total - d0, 1);
    check(busy === 1'b0, "idle_after_dump", int'(busy), 0);
  endtask

  initial begin
    for (int n = 0; n < 1024; n++) mem[n] = (n % 3 == 0);
    for (int k = 0; k < 2; k++) begin
      int b;
      b = 0;
      for (int i = 0; i < 8; i++) if (8 * k + i < 12) b += (1 << i);
      exp12[k] = 8'(b);
    end

    repeat (3) @(negedge clk);
    check(busy === 1'b0 && done === 1'b0 && tx_start === 1'b0, "reset_ctrl",
          int'({busy, done, tx_start}), 0);
    check(tx_data === 8'h00, "reset_tx_data", int'(tx_data), 0);
    check(ram_addr === 10'd0, "reset_ram_addr", int'(ram_addr), 0);
    rst_n = 1'b1;
    tick();

    // Model pinned to hand-derived bytes for the n%3==0 pattern and DEPTH=12
    build_exp();
    check(exp_b[0] == 8'h49, "model_byte0", int'(exp_b[0]), 'h49);
    check(exp_b[1] == 8'h92, "model_byte1", int'(exp_b[1]), 'h92);
    check(exp_b[2] == 8'h24, "model_byte2", int'(exp_b[2]), 'h24);
    check(exp_b[97] == exp_b[1], "model_period3", int'(exp_b[97]), int'(exp_b[1]));
    check(exp12[0] == 8'hFF && exp12[1] == 8'h0F, "model_d12", int'({exp12[0], exp12[1]}), 'hFF0F);

    // Slow UART, fixed pattern
    rdy_len = 100;
    run_dump(1'b0, -1, 0);

    // Short dump with a zero-padded final byte
    start12 = 1'b1;
    tick();
    start12 = 1'b0;
    for (int c = 0; c < 200 && done12_cnt == 0; c++) tick();
    repeat (10) tick();
    check(done12_cnt == 1, "done_d12", done12_cnt, 1);
    check(n12 == 2, "byte_count_d12", n12, 2);
    check(busy12 === 1'b0, "idle_d12", int'(busy12), 0);

    // tx_rdy held low at the first SEND, then random UART timing
    fill_random();
    rand_len = 1'b1;
    rdy_len  = $urandom_range(0, 20);
    run_dump(1'b0, -1, 5000);

    // start pulses at byte 10 and at done are ignored
    fill_random();
    run_dump(1'b1, -1, 0);

    // Asynchronous reset in the middle of byte 40
    fill_random();
    run_dump(1'b0, 40, 0);
    repeat (5) tick();
    #3 rst_n = 1'b0;
    #1;
    check(busy === 1'b0 && tx_start === 1'b0 && done === 1'b0, "async_reset",
          int'({busy, tx_start, done}), 0);
    check(ram_addr === 10'd0, "async_reset_addr", int'(ram_addr), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check(busy === 1'b0 && tx_start === 1'b0, "idle_after_reset", int'({busy, tx_start}), 0);

    // Fresh dump with an instant UART: strict address order and guard spacing
    fill_random();
    rand_len  = 1'b0;
    rdy_len   = 0;
    chk_order = 1'b1;
    run_dump(1'b0, -1, 0);
    chk_order = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
